// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: payload + control bundle behind a valid/ready handshake with a 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid when empty; sustains 1 entry/cycle while out_ready=1.
// Backpressure: in_ready is a flop (no combinational path from out_ready/flush); absorbs one extra entry into skid.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_data/in_ctrl upstream payload and control
//   flush                 synchronous squash of all held entries (highest priority)
//   out_valid/out_ready   downstream handshake; out_data/out_ctrl main-entry payload and control
//   stall_cnt/bubble_cnt  statistics counters, present only when PIPE_STATS_EN is defined
module pipe_stage_reg #(
    parameter int                 DATA_W   = 160,
    parameter int                 CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;

    logic                w_accept;
    logic                w_fire;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;

    assign w_accept = in_valid & r_in_ready;
    assign w_fire   = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_load_main_in = 1'b1;
                    w_state_nxt    = ONE;
                end
            end
            ONE: begin
                if (w_accept && w_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = FULL;
                end else if (w_fire) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_fire) begin
                    w_load_main_skid = 1'b1;
                    w_state_nxt      = ONE;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Flush wins: an accepted input is swallowed, and main keeps its old
        // payload so out_data simply holds while the stage is a bubble.
        if (flush) begin
            w_state_nxt      = EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_data <= '0;
            r_main_ctrl <= CTRL_NOP;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state     <= w_state_nxt;
            // Handshake flags are registered copies of the next-state decode.
            r_in_ready  <= (w_state_nxt != FULL);
            r_out_valid <= (w_state_nxt != EMPTY);
            if (w_load_main_in) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_out_valid ? r_main_ctrl : CTRL_NOP;

`ifdef PIPE_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_out_valid && !out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (!r_out_valid)              r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, async reset pulse, randomized run vs a queue model.
module tb_pipe_stage_reg;

    localparam int          DW  = 160;
    localparam int          CW  = 16;
    localparam logic [15:0] NOP = 16'h8013;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
`ifdef PIPE_STATS_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   bubble_cnt;
`endif

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: the stage is a FIFO of capacity 2 whose ready flag is
    // the registered "not full" condition.
    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t        q[$];
    bit          m_ready;
    logic [DW-1:0] m_last;
    logic [31:0] m_stall;
    logic [31:0] m_bub;

    task automatic model_reset();
        q.delete();
        m_ready = 1'b1;
        m_last  = '0;
        m_stall = '0;
        m_bub   = '0;
    endtask

    task automatic model_edge();
        bit acc;
        bit fire;
        ent_t e;
        acc  = in_valid && m_ready;
        fire = (q.size() > 0) && out_ready;
        if (q.size() == 0)   m_bub++;
        else if (!out_ready) m_stall++;
        e.d = in_data;
        e.c = in_ctrl;
        if (flush) q.delete();
        else begin
            if (fire) void'(q.pop_front());
            if (acc)  q.push_back(e);
        end
        m_ready = (q.size() < 2);
        if (q.size() > 0) m_last = q[0].d;
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, " out_valid"}, 192'(out_valid), 192'(q.size() > 0));
        chk({tag, " in_ready"},  192'(in_ready),  192'(m_ready));
        chk({tag, " out_data"},  192'(out_data),  192'(m_last));
        chk({tag, " out_ctrl"},  192'(out_ctrl),  192'((q.size() > 0) ? q[0].c : NOP));
`ifdef PIPE_STATS_EN
        chk({tag, " stall_cnt"},  192'(stall_cnt),  192'(m_stall));
        chk({tag, " bubble_cnt"}, 192'(bubble_cnt), 192'(m_bub));
`endif
    endtask

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          ordy;
        logic          fl;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [CW-1:0] e_oc;
        logic          e_ir;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic iv, input int d, input logic [CW-1:0] c, input logic ordy,
                       input logic fl, input logic e_ov, input int e_od, input logic [CW-1:0] e_oc,
                       input logic e_ir);
        vec_t v;
        v.iv = iv; v.d = DW'(d); v.c = c; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_od = DW'(e_od); v.e_oc = e_oc; v.e_ir = e_ir;
        vt.push_back(v);
    endtask

    initial begin
        // Directed table: {iv, data, ctrl, out_ready, flush} -> {out_valid, out_data, out_ctrl, in_ready}
        // First transfer, then drain.
        add(1, 'hA5, 16'h00F3, 1, 0,   1, 'hA5, 16'h00F3, 1);
        add(0, 0,    16'h0,    1, 0,   0, 'hA5, NOP,      1);
        // Streaming 1..8 with out_ready held high.
        for (int n = 1; n <= 8; n++)
            add(1, n, 16'h0010 + 16'(n), 1, 0,   1, n, 16'h0010 + 16'(n), 1);
        add(0, 0, 16'h0, 1, 0,   0, 8, NOP, 1);
        // Back-pressure: entry 2 lands in skid, ready drops, three stalled cycles.
        add(1, 1, 16'h0011, 1, 0,   1, 1, 16'h0011, 1);
        add(1, 2, 16'h0012, 0, 0,   1, 1, 16'h0011, 0);
        add(1, 3, 16'h0013, 0, 0,   1, 1, 16'h0011, 0);
        add(1, 3, 16'h0013, 0, 0,   1, 1, 16'h0011, 0);
        add(1, 3, 16'h0013, 1, 0,   1, 2, 16'h0012, 1);
        add(1, 3, 16'h0013, 1, 0,   1, 3, 16'h0013, 1);
        add(1, 4, 16'h0014, 1, 0,   1, 4, 16'h0014, 1);
        add(0, 0, 16'h0,    1, 0,   0, 4, NOP,      1);
        // Flush while FULL with in_valid high.
        add(1, 5, 16'h0015, 0, 0,   1, 5, 16'h0015, 1);
        add(1, 6, 16'h0016, 0, 0,   1, 5, 16'h0015, 0);
        add(1, 7, 16'h0017, 0, 1,   0, 5, NOP,      1);
        // Flush in ONE swallows a same-cycle accept.
        add(1, 8, 16'h0018, 0, 0,   1, 8, 16'h0018, 1);
        add(1, 9, 16'h0019, 0, 1,   0, 8, NOP,      1);
        add(0, 0, 16'h0,    1, 0,   0, 8, NOP,      1);

        reset = 1'b1;
        drive(0, '0, '0, 0, 0);
        model_reset();
        #12;
        chk("reset in_ready",  192'(in_ready),  192'(1));
        chk("reset out_valid", 192'(out_valid), 192'(0));
        chk("reset out_ctrl",  192'(out_ctrl),  192'(NOP));
        chk("reset out_data",  192'(out_data),  192'(0));
        reset = 1'b0;

        foreach (vt[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vt[i].iv, vt[i].d, vt[i].c, vt[i].ordy, vt[i].fl);
            tick();
            chk({tag, " out_valid"}, 192'(out_valid), 192'(vt[i].e_ov));
            chk({tag, " out_data"},  192'(out_data),  192'(vt[i].e_od));
            chk({tag, " out_ctrl"},  192'(out_ctrl),  192'(vt[i].e_oc));
            chk({tag, " in_ready"},  192'(in_ready),  192'(vt[i].e_ir));
        end
        cmp_model("post-table");

        // Stall and idle sequence for the statistics counters.
        drive(1, DW'('h77), 16'h0077, 0, 0);
        tick();
        drive(0, '0, '0, 0, 0);
        for (int k = 0; k < 4; k++) tick();
        drive(0, '0, '0, 1, 0);
        for (int k = 0; k < 4; k++) tick();
        cmp_model("stats-seq");

        // Fill to FULL, then pulse reset between edges.
        drive(1, DW'('hAB), 16'h00AB, 0, 0);
        tick();
        drive(1, DW'('hCD), 16'h00CD, 0, 0);
        tick();
        cmp_model("pre-areset");
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("areset out_valid", 192'(out_valid), 192'(0));
        chk("areset in_ready",  192'(in_ready),  192'(1));
        chk("areset out_ctrl",  192'(out_ctrl),  192'(NOP));
        chk("areset out_data",  192'(out_data),  192'(0));
        #1;
        reset = 1'b0;
        drive(1, DW'('hEE), 16'h00EE, 1, 0);
        tick();
        chk("restart out_valid", 192'(out_valid), 192'(1));
        chk("restart out_data",  192'(out_data),  192'('hEE));
        cmp_model("restart");

        // Randomized traffic against the queue model.
        for (int k = 0; k < 400; k++) begin
            logic [DW-1:0] rd;
            rd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            drive(1'($urandom_range(0, 3) != 0), rd, 16'($urandom()),
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
            tick();
            cmp_model($sformatf("rand%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
